// File: rtl/fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO.
package fifo_pkg;

    function automatic int fifo_clog2(input int v);
        return $clog2(v);
    endfunction

    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = fifo_clog2(FIFO_DEPTH);

    typedef logic [FIFO_ADDR_W:0] cnt_t;

endpackage

// File: rtl/sync_fifo_counter.sv
// Up/down occupancy counter; increment wins when both are requested.
module counter #(
    parameter int N_BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [N_BITS-1:0] q_o
);

    logic [N_BITS-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (inc_i) begin
            q_q <= q_q + 1'b1;
        end else if (dec_i) begin
            q_q <= q_q - 1'b1;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level flags and high-water mark.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = fifo_clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   high_water
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   cnt_raw, base_q, hw_q;
    logic              push, pop, inc, dec;

    assign push = wr_valid & wr_ready & ~clear;
    assign pop  = rd_valid & rd_ready & ~clear;
    assign inc  = push & ~pop;
    assign dec  = pop & ~push;

    counter #(
        .N_BITS(ADDR_W+1)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(inc),
        .dec_i(dec),
        .q_o  (cnt_raw)
    );

    // The counter has no sync clear: a clear snapshots its value as the new
    // zero point, and occupancy is the modular distance from that snapshot.
    assign count = cnt_raw - base_q;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign wr_ready     = ~full;
    assign rd_valid     = ~empty;
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign high_water   = hw_q;
    assign rd_data      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            base_q   <= '0;
            hw_q     <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            base_q   <= cnt_raw;
            hw_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (count > hw_q) begin
                hw_q <= count;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random checks of sync_fifo against a queue-based model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    cnt_t       count;
    logic       full, empty, almost_full, almost_empty;
    cnt_t       high_water;

    int n_assert = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    int         mhw = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .high_water(high_water)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(n != 0));
        chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("high_water", 32'(high_water), 32'(mhw));
        if (n != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    // Check state, drive one cycle of inputs, advance the model at the edge.
    task automatic cyc(input bit wv, input logic [7:0] wd,
                       input bit rr, input bit clr);
        bit p, q;
        int n;
        chk_all();
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clear    = clr;
        n = mq.size();
        p = wv && (n < DEPTH);
        q = rr && (n > 0);
        @(posedge clk);
        if (clr) begin
            mq.delete();
            mhw = 0;
        end else begin
            if (n > mhw) mhw = n;
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(wd);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mq.delete();
        mhw = 0;
        chk_all();
        @(negedge clk);
        chk_all();
        rst_n = 1'b1;
    endtask

    task automatic fill_drain();
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("s1_count", 32'(count), 32'd16);
        chk("s1_full", 32'(full), 32'd1);
        chk("s1_hw", 32'(high_water), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("s2_order", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("s2_empty", 32'(empty), 32'd1);
        chk("s2_hw", 32'(high_water), 32'd16);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        fill_drain();

        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("s3_delay", 32'(rd_data), 32'(8'(8'h40 + i)));
            cyc(1'b1, 8'(8'h45 + i), 1'b1, 1'b0);
            chk("s3_count", 32'(count), 32'd5);
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        chk("s4_pre", 32'(rd_valid), 32'd0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("s4_valid", 32'(rd_valid), 32'd1);
        chk("s4_data", 32'(rd_data), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("s5_count", 32'(count), 32'd0);
        chk("s5_hw", 32'(high_water), 32'd0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("s5_fresh", 32'(rd_data), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        chk("s6_pre", 32'(count), 32'd7);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        #2;
        do_reset();
        wr_valid = 1'b0;
        fill_drain();

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom),
                1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 63) == 0));
        end
        chk_all();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
